mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-ported memory bus between the instruction-fetch port and the load/store data port of the pako32 core. Selects one requester at a time and keeps at most one transaction outstanding. Generates byte enables and write-data lane placement from the access size, and aligns and extends read data. Sits between the core (`control` plus datapath) and the memory/peripheral bus.

## Interface
- `ADDR_W`, default 32: address width.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `if_req_i`  in  1  fetch request; held with `if_addr_i` until `if_gnt_o`.
- `if_addr_i`  in  ADDR_W  fetch address (word-aligned, bits [1:0] ignored).
- `if_gnt_o`  out  1  fetch request accepted by bus.
- `if_rvalid_o`  out  1  fetch data valid, 1-cycle pulse.
- `if_rdata_o`  out  32  fetch data.
- `d_req_i`  in  1  data request; fields held until `d_gnt_o` or `d_err_o`.
- `d_we_i`  in  1  1 = store, 0 = load.
- `d_addr_i`  in  ADDR_W  byte address.
- `d_acc_i`  in  2  size: `MEM_ACCESS_BYTE`=0, `MEM_ACCESS_HALF`=1, `MEM_ACCESS_WORD`=2.
- `d_sext_i`  in  1  sign-extend load result.
- `d_wdata_i`  in  32  store data, LSB-justified.
- `d_gnt_o`  out  1  data request accepted by bus.
- `d_done_o`  out  1  load data valid or store acknowledged, 1-cycle pulse.
- `d_err_o`  out  1  misaligned access, 1-cycle pulse; no bus transaction.
- `d_rdata_o`  out  32  aligned, extended load data.
- `mem_req_o`, `mem_we_o`  out  1  bus request / write.
- `mem_addr_o`  out  ADDR_W  word address ([1:0] forced 0).
- `mem_be_o`  out  4  byte enables.
- `mem_wdata_o`  out  32  lane-placed write data.
- `mem_gnt_i`  in  1  bus accepts request this cycle.
- `mem_rvalid_i`  in  1  response (read data or write ack), ≥1 cycle after accept.
- `mem_rdata_i`  in  32  read data.

## Operation
- FSM states: `IDLE`, `WAIT_IF`, `WAIT_D`. Reset → `IDLE`; while `rst_i`=1 every output is 0.
- In `IDLE` arbitration is combinational. The winner drives `mem_*` in the same cycle.
- Default policy is fixed priority: data beats fetch.
- A transaction is accepted when `mem_req_o & mem_gnt_i`. The requester's `*_gnt_o` equals that term. Accept by fetch → `WAIT_IF`; accept by data → `WAIT_D`. Without `mem_gnt_i` the state stays `IDLE` and arbitration is re-evaluated next cycle.
- Accepted request fields are latched at accept: requester, `d_addr_i`[1:0], `d_acc_i`, `d_sext_i`.
- In `WAIT_IF`/`WAIT_D`, `mem_req_o`=0. On `mem_rvalid_i`, pulse `if_rvalid_o` or `d_done_o` in the same cycle, then go to `IDLE`. The next request is issued no earlier than the following cycle.
- Byte lanes:
  - byte → `be = 1<<a[1:0]`, `wdata` = byte replicated ×4.
  - half → `be = 4'b0011<<a[1:0]`, `wdata` = half replicated ×2.
  - word → `be = 4'b1111`.
- Load data: shift `mem_rdata_i` right by 8·a[1:0] using the latched offset. Truncate to the size, then zero- or sign-extend per the latched `d_sext_i`. `d_rdata_o`=0 outside `d_done_o` cycles for stores.
- Misaligned data access (half with a[0]=1, word with a[1:0]≠0, or `d_acc_i`=3) wins arbitration in `IDLE`:
  - no `mem_req_o`, no `d_gnt_o`;
  - `d_err_o`=1 in that cycle;
  - fetch is not granted that cycle.
- `mem_rvalid_i` in `IDLE` is ignored. This covers stray responses after reset mid-transaction.
- Reset asserted in `WAIT_*`: the outstanding transaction is dropped, no done/rvalid pulse is generated, and the FSM is in `IDLE` after release.

## Timing
- Grant latency: 0 cycles from request when the bus grants immediately.
- Minimum load-to-data latency: 1 cycle after accept. Throughput: one transaction per 2 cycles.
- Request fields must be stable from `*_req_i` rise until grant. Dropping a request before grant is legal only while it is not selected.
- Simultaneous fetch and data requests in `IDLE`: the policy decides; the loser waits with no pulse.

## Configuration
- `MEM_ARBITER_RR_EN` defined: round-robin arbitration. A 1-bit `last` register is updated on each accept, and the non-last requester wins a conflict. `last` resets to data (fetch wins the first conflict). Misaligned data still responds via `d_err_o` only when data is selected.
- `MEM_ARBITER_RR_EN` undefined: fixed data priority, no `last` register.

## Structure
- `MEM_ACCESS_*` size constants live in the shared `const.v`. Add state encodings `MEM_ARB_ST_*` there.
- One sub-module, `mem_lane_align`, is combinational:
  - inputs: size, offset, sext, wdata, rdata;
  - outputs: be, placed wdata, extended rdata, misaligned flag.
- `mem_arbiter` holds the FSM, latches and policy.

## Test plan
- Data load byte, `d_addr_i`=0x103, sext=1, mem returns 0x80FF_0000 one cycle after grant → `mem_be_o`=4'b1000, `mem_addr_o`=0x100, `d_rdata_o`=0xFFFF_FF80 with `d_done_o` pulse.
- Store half 0xBEEF to 0x202 → `mem_be_o`=4'b1100, `mem_wdata_o`=0xBEEF_BEEF, `mem_we_o`=1; `d_done_o` on `mem_rvalid_i`.
- Fetch and data request same cycle, `mem_gnt_i`=1:
  - fixed: `d_gnt_o`=1, then `if_gnt_o` two cycles later;
  - RR after reset: `if_gnt_o` first, then data.
- Word load at 0x102 → `d_err_o`=1 that cycle, `mem_req_o`=0, no `d_done_o`.
- `mem_gnt_i` held 0 for 3 cycles with fetch pending → `mem_req_o` high 3 cycles, address stable, grant on cycle 4.
- Assert `rst_i` in `WAIT_D`, then deliver `mem_rvalid_i` after release → no `d_done_o`, FSM `IDLE`, next fetch granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the pako32 memory arbiter: access sizes, FSM state
// encodings and the alignment rule used to reject misaligned data accesses.
package mem_arbiter_pkg;

    localparam logic [1:0] MEM_ACCESS_BYTE = 2'd0;
    localparam logic [1:0] MEM_ACCESS_HALF = 2'd1;
    localparam logic [1:0] MEM_ACCESS_WORD = 2'd2;

    typedef enum logic [1:0] {
        MEM_ARB_ST_IDLE    = 2'd0,
        MEM_ARB_ST_WAIT_IF = 2'd1,
        MEM_ARB_ST_WAIT_D  = 2'd2
    } mem_arb_state_e;

    // Size code 3 is undefined and is reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] acc, input logic [1:0] off);
        case (acc)
            MEM_ACCESS_BYTE: is_misaligned = 1'b0;
            MEM_ACCESS_HALF: is_misaligned = off[0];
            MEM_ACCESS_WORD: is_misaligned = |off;
            default:         is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response and bus-side signals of the memory arbiter.
// slave = the arbiter's view, master = the surrounding core/bus environment.
interface mem_arbiter_if #(parameter int ADDR_W = 32);

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [1:0]        d_acc_i;
    logic              d_sext_i;
    logic [31:0]       d_wdata_i;
    logic              d_gnt_o;
    logic              d_done_o;
    logic              d_err_o;
    logic [31:0]       d_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_acc_i, d_sext_i, d_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_gnt_o, d_done_o, d_err_o, d_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_acc_i, d_sext_i, d_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_gnt_o, d_done_o, d_err_o, d_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: byte enables and replicated write data from
// size/offset, and right-aligned, zero/sign-extended read data.
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  acc_i,
    input  logic [1:0]  off_i,
    input  logic        sext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [31:0] shifted;
    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted;
        case (acc_i)
            MEM_ACCESS_BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext_i & shifted[7]}}, shifted[7:0]};
            end
            MEM_ACCESS_HALF: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sext_i & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
        misaligned_o = is_misaligned(acc_i, off_i);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-ported pako32 memory bus, one transaction
// outstanding. Define MEM_ARBITER_RR_EN for round-robin instead of data priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mem_arbiter_if.slave   bus
);

    mem_arb_state_e state_q, state_d;
    logic [1:0]     acc_q, off_q;
    logic           sext_q, we_q;

    logic              idle, d_sel, if_sel, d_issue, req_c, accept;
    logic [1:0]        acc_sel, off_sel;
    logic              sext_sel, misaligned;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata, lane_rdata;
    logic [ADDR_W-1:0] d_word_addr, if_word_addr;
    logic              unused_if_off;

    assign idle         = (state_q == MEM_ARB_ST_IDLE);
    assign d_word_addr  = {bus.d_addr_i[ADDR_W-1:2], 2'b00};
    assign if_word_addr = {bus.if_addr_i[ADDR_W-1:2], 2'b00};
    assign unused_if_off = ^bus.if_addr_i[1:0];

    // Live request fields drive the lanes while arbitrating; once a load is
    // outstanding the latched copies shape the returning data.
    assign acc_sel  = idle ? bus.d_acc_i        : acc_q;
    assign off_sel  = idle ? bus.d_addr_i[1:0]  : off_q;
    assign sext_sel = idle ? bus.d_sext_i       : sext_q;

    mem_lane_align u_lane (
        .acc_i        (acc_sel),
        .off_i        (off_sel),
        .sext_i       (sext_sel),
        .wdata_i      (bus.d_wdata_i),
        .rdata_i      (bus.mem_rdata_i),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .rdata_o      (lane_rdata),
        .misaligned_o (misaligned)
    );

`ifdef MEM_ARBITER_RR_EN
    logic last_if_q;
    // On a conflict the requester that did not win last time goes first.
    assign d_sel = bus.d_req_i & (~bus.if_req_i | last_if_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_if_q <= 1'b0;
        end else if (accept) begin
            last_if_q <= if_sel;
        end
    end
`else
    assign d_sel = bus.d_req_i;
`endif

    assign if_sel  = bus.if_req_i & ~d_sel;
    assign d_issue = d_sel & ~misaligned;
    assign req_c   = idle & ~rst_i & (d_issue | if_sel);
    assign accept  = req_c & bus.mem_gnt_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MEM_ARB_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= MEM_ACCESS_BYTE;
            off_q  <= 2'b00;
            sext_q <= 1'b0;
            we_q   <= 1'b0;
        end else if (accept) begin
            acc_q  <= bus.d_acc_i;
            off_q  <= bus.d_addr_i[1:0];
            sext_q <= bus.d_sext_i;
            we_q   <= bus.d_we_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_ARB_ST_IDLE: begin
                if (accept) begin
                    state_d = d_issue ? MEM_ARB_ST_WAIT_D : MEM_ARB_ST_WAIT_IF;
                end
            end
            MEM_ARB_ST_WAIT_IF,
            MEM_ARB_ST_WAIT_D: begin
                if (bus.mem_rvalid_i) begin
                    state_d = MEM_ARB_ST_IDLE;
                end
            end
            default: state_d = MEM_ARB_ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_be_o    = 4'b0000;
        bus.mem_wdata_o = 32'h0;
        bus.if_gnt_o    = 1'b0;
        bus.if_rvalid_o = 1'b0;
        bus.if_rdata_o  = 32'h0;
        bus.d_gnt_o     = 1'b0;
        bus.d_done_o    = 1'b0;
        bus.d_err_o     = 1'b0;
        bus.d_rdata_o   = 32'h0;
        if (!rst_i) begin
            case (state_q)
                MEM_ARB_ST_IDLE: begin
                    bus.mem_req_o = req_c;
                    if (d_issue) begin
                        bus.mem_we_o    = bus.d_we_i;
                        bus.mem_addr_o  = d_word_addr;
                        bus.mem_be_o    = lane_be;
                        bus.mem_wdata_o = lane_wdata;
                    end else if (if_sel) begin
                        bus.mem_addr_o = if_word_addr;
                        bus.mem_be_o   = 4'b1111;
                    end
                    bus.d_gnt_o  = accept & d_issue;
                    bus.if_gnt_o = accept & if_sel;
                    bus.d_err_o  = d_sel & misaligned;
                end
                MEM_ARB_ST_WAIT_IF: begin
                    bus.if_rvalid_o = bus.mem_rvalid_i;
                    bus.if_rdata_o  = bus.mem_rvalid_i ? bus.mem_rdata_i : 32'h0;
                end
                MEM_ARB_ST_WAIT_D: begin
                    bus.d_done_o  = bus.mem_rvalid_i;
                    bus.d_rdata_o = (bus.mem_rvalid_i && !we_q) ? lane_rdata : 32'h0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand-written sequences for conflicts, bus stalls and reset mid-transaction.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32)) bus();

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.if_req_i     = 1'b0;
        bus.if_addr_i    = 32'h0;
        bus.d_req_i      = 1'b0;
        bus.d_we_i       = 1'b0;
        bus.d_addr_i     = 32'h0;
        bus.d_acc_i      = 2'd0;
        bus.d_sext_i     = 1'b0;
        bus.d_wdata_i    = 32'h0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic data_req(input logic we, input logic [31:0] addr, input logic [1:0] acc,
                            input logic sext, input logic [31:0] wdata);
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = we;
        bus.d_addr_i  = addr;
        bus.d_acc_i   = acc;
        bus.d_sext_i  = sext;
        bus.d_wdata_i = wdata;
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [1:0]  d_acc;
        logic        d_sext;
        logic [31:0] d_wdata;
        logic        gnt;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_d_err;
        logic [31:0] rsp;
        logic        e_if_rv;
        logic        e_d_done;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];
    vec_t v;

    initial begin
        // if_req if_addr | d_req we addr acc sext wdata | gnt | req we addr be wdata | if_gnt d_gnt err | rsp if_rv done rdata
        vecs[0]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h103, 2'd0, 1'b1, 32'h0, 1'b1,
                     1'b1, 1'b0, 32'h100, 4'h8, 32'h0, 1'b0, 1'b1, 1'b0,
                     32'h80FF_0000, 1'b0, 1'b1, 32'hFFFF_FF80};
        vecs[1]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h202, 2'd1, 1'b0, 32'h0000_BEEF, 1'b1,
                     1'b1, 1'b1, 32'h200, 4'hC, 32'hBEEF_BEEF, 1'b0, 1'b1, 1'b0,
                     32'h1234_5678, 1'b0, 1'b1, 32'h0};
        vecs[2]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h402, 2'd1, 1'b0, 32'h0, 1'b1,
                     1'b1, 1'b0, 32'h400, 4'hC, 32'h0, 1'b0, 1'b1, 1'b0,
                     32'h9ABC_1234, 1'b0, 1'b1, 32'h0000_9ABC};
        vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 2'd1, 1'b1, 32'h0, 1'b1,
                     1'b1, 1'b0, 32'h400, 4'h3, 32'h0, 1'b0, 1'b1, 1'b0,
                     32'h1234_F00D, 1'b0, 1'b1, 32'hFFFF_F00D};
        vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 2'd2, 1'b1, 32'h0, 1'b1,
                     1'b1, 1'b0, 32'h500, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0,
                     32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h601, 2'd0, 1'b0, 32'h1234_56A5, 1'b1,
                     1'b1, 1'b1, 32'h600, 4'h2, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0,
                     32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h700, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b1,
                     1'b1, 1'b1, 32'h700, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0,
                     32'h0, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h802, 2'd0, 1'b0, 32'h0, 1'b1,
                     1'b1, 1'b0, 32'h800, 4'h4, 32'h0, 1'b0, 1'b1, 1'b0,
                     32'hFFC3_FFFF, 1'b0, 1'b1, 32'h0000_00C3};
        vecs[8]  = '{1'b1, 32'h1003, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b1,
                     1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0,
                     32'h1357_9BDF, 1'b1, 1'b0, 32'h1357_9BDF};
        // Misaligned word against a pending fetch: error only, fetch not granted.
        vecs[9]  = '{1'b1, 32'h1100, 1'b1, 1'b0, 32'h102, 2'd2, 1'b0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1,
                     32'h5555_5555, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h105, 2'd1, 1'b0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1,
                     32'h0, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 2'd3, 1'b0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1,
                     32'h0, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h900, 2'd2, 1'b0, 32'h0, 1'b0,
                     1'b1, 1'b0, 32'h900, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0,
                     32'h7777_7777, 1'b0, 1'b0, 32'h0};

        // Reset holds every output low even with requests and responses present.
        clear_inputs();
        bus.if_req_i = 1'b1;
        data_req(1'b0, 32'h104, 2'd2, 1'b0, 32'h0);
        bus.mem_gnt_i    = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        #3;
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("rst_if_gnt", 32'(bus.if_gnt_o), 32'h0);
        chk("rst_d_gnt", 32'(bus.d_gnt_o), 32'h0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        next_cycle();
        clear_inputs();
        next_cycle();
        rst = 1'b0;
        #4;
        chk("idle_mem_req", 32'(bus.mem_req_o), 32'h0);
        $display("seq reset: done");
        next_cycle();

        // Simultaneous fetch and data request, first conflict after reset.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h2000;
        data_req(1'b0, 32'h900, 2'd2, 1'b0, 32'h0);
        bus.mem_gnt_i = 1'b1;
        #4;
`ifdef MEM_ARBITER_RR_EN
        chk("cf_if_gnt0", 32'(bus.if_gnt_o), 32'h1);
        chk("cf_d_gnt0", 32'(bus.d_gnt_o), 32'h0);
        chk("cf_addr0", bus.mem_addr_o, 32'h2000);
        next_cycle();
        bus.if_req_i     = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h3333_4444;
        #4;
        chk("cf_if_rvalid", 32'(bus.if_rvalid_o), 32'h1);
        chk("cf_wait_d_gnt", 32'(bus.d_gnt_o), 32'h0);
        next_cycle();
        bus.mem_rvalid_i = 1'b0;
        #4;
        chk("cf_d_gnt2", 32'(bus.d_gnt_o), 32'h1);
        chk("cf_addr2", bus.mem_addr_o, 32'h900);
        next_cycle();
        bus.d_req_i      = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h1111_2222;
        #4;
        chk("cf_d_done", 32'(bus.d_done_o), 32'h1);
        chk("cf_d_rdata", bus.d_rdata_o, 32'h1111_2222);
`else
        chk("cf_d_gnt0", 32'(bus.d_gnt_o), 32'h1);
        chk("cf_if_gnt0", 32'(bus.if_gnt_o), 32'h0);
        chk("cf_addr0", bus.mem_addr_o, 32'h900);
        next_cycle();
        bus.d_req_i      = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h1111_2222;
        #4;
        chk("cf_d_done", 32'(bus.d_done_o), 32'h1);
        chk("cf_d_rdata", bus.d_rdata_o, 32'h1111_2222);
        chk("cf_wait_if_gnt", 32'(bus.if_gnt_o), 32'h0);
        next_cycle();
        bus.mem_rvalid_i = 1'b0;
        #4;
        chk("cf_if_gnt2", 32'(bus.if_gnt_o), 32'h1);
        chk("cf_addr2", bus.mem_addr_o, 32'h2000);
        next_cycle();
        bus.if_req_i     = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h3333_4444;
        #4;
        chk("cf_if_rvalid", 32'(bus.if_rvalid_o), 32'h1);
        chk("cf_if_rdata", bus.if_rdata_o, 32'h3333_4444);
`endif
        next_cycle();
        clear_inputs();
        $display("seq conflict: done");

        // Bus stalls a pending fetch for three cycles, then grants.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h3000;
        for (int k = 0; k < 3; k++) begin
            #4;
            chk("stall_mem_req", 32'(bus.mem_req_o), 32'h1);
            chk("stall_addr", bus.mem_addr_o, 32'h3000);
            chk("stall_if_gnt", 32'(bus.if_gnt_o), 32'h0);
            next_cycle();
        end
        bus.mem_gnt_i = 1'b1;
        #4;
        chk("stall_if_gnt4", 32'(bus.if_gnt_o), 32'h1);
        next_cycle();
        clear_inputs();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hA5A5_0001;
        #4;
        chk("stall_if_rvalid", 32'(bus.if_rvalid_o), 32'h1);
        chk("stall_if_rdata", bus.if_rdata_o, 32'hA5A5_0001);
        next_cycle();
        clear_inputs();
        $display("seq stall: done");

        // Reset while a load is outstanding; the late response must be dropped.
        data_req(1'b0, 32'hA00, 2'd2, 1'b0, 32'h0);
        bus.mem_gnt_i = 1'b1;
        #4;
        chk("rw_d_gnt", 32'(bus.d_gnt_o), 32'h1);
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hDEAD_0000;
        #4;
        chk("rw_rst_d_done", 32'(bus.d_done_o), 32'h0);
        next_cycle();
        rst = 1'b0;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h4000;
        bus.mem_gnt_i = 1'b1;
        #4;
        chk("rw_late_d_done", 32'(bus.d_done_o), 32'h0);
        chk("rw_late_d_rdata", bus.d_rdata_o, 32'h0);
        chk("rw_if_gnt", 32'(bus.if_gnt_o), 32'h1);
        chk("rw_if_addr", bus.mem_addr_o, 32'h4000);
        next_cycle();
        clear_inputs();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h0000_4444;
        #4;
        chk("rw_if_rvalid", 32'(bus.if_rvalid_o), 32'h1);
        chk("rw_d_done_after", 32'(bus.d_done_o), 32'h0);
        next_cycle();
        clear_inputs();
        $display("seq reset-in-wait: done");

        // Table: one arbitration cycle, then a response cycle (a stray response if nothing was accepted).
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            bus.if_req_i  = v.if_req;
            bus.if_addr_i = v.if_addr;
            data_req(v.d_we, v.d_addr, v.d_acc, v.d_sext, v.d_wdata);
            bus.d_req_i   = v.d_req;
            bus.mem_gnt_i = v.gnt;
            #4;
            chk($sformatf("v%0d_mem_req", i), 32'(bus.mem_req_o), 32'(v.e_req));
            chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we_o), 32'(v.e_we));
            chk($sformatf("v%0d_mem_addr", i), bus.mem_addr_o, v.e_addr);
            chk($sformatf("v%0d_mem_be", i), 32'(bus.mem_be_o), 32'(v.e_be));
            chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata_o, v.e_wdata);
            chk($sformatf("v%0d_if_gnt", i), 32'(bus.if_gnt_o), 32'(v.e_if_gnt));
            chk($sformatf("v%0d_d_gnt", i), 32'(bus.d_gnt_o), 32'(v.e_d_gnt));
            chk($sformatf("v%0d_d_err", i), 32'(bus.d_err_o), 32'(v.e_d_err));
            next_cycle();
            clear_inputs();
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = v.rsp;
            #4;
            chk($sformatf("v%0d_if_rvalid", i), 32'(bus.if_rvalid_o), 32'(v.e_if_rv));
            chk($sformatf("v%0d_if_rdata", i), bus.if_rdata_o, v.e_if_rv ? v.e_rdata : 32'h0);
            chk($sformatf("v%0d_d_done", i), 32'(bus.d_done_o), 32'(v.e_d_done));
            chk($sformatf("v%0d_d_rdata", i), bus.d_rdata_o, v.e_d_done ? v.e_rdata : 32'h0);
            chk($sformatf("v%0d_err_pulse", i), 32'(bus.d_err_o), 32'h0);
            next_cycle();
            clear_inputs();
            $display("vec %0d: addr=0x%08h acc=%0d we=%0d done", i,
                     v.d_req ? v.d_addr : v.if_addr, v.d_acc, v.d_we);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
